// File: rtl/tbec_encode_arbiter_if.sv
// Requester and result handshake bundle for the shared TBEC encoder arbiter.
// The arbiter takes the slave side; requesters and the consumer take the master side.
interface tbec_encode_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int CW   = 32,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [CW-1:0]      out_code;
    logic [IDW-1:0]     out_id;
    logic               out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_code, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_code, out_id
    );
endinterface

// File: rtl/tbec_encode_arbiter.sv
// Round-robin arbiter sharing one combinational TBEC-RSC encoder among NREQ
// requesters; the encoded word is held in a one-deep output slot with its source ID.
module tbec_encode_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int CW   = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    tbec_encode_arbiter_if.slave bus,
    output logic [CW-1:0]        enc_data_in,
    output logic                 enc_en,
    input  logic [CW-1:0]        enc_data_out,
    output logic                 busy,
    output logic [31:0]          enc_count
);

    // First valid requester after 'last', wrapping; 'last' itself has lowest priority.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0]   r;
        logic [IDW-1:0] idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (vld[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    logic           vld_p1;
    logic [CW-1:0]  code_p1;
    logic [IDW-1:0] id_p1;
    logic [31:0]    cnt_p1;
    logic [IDW-1:0] last_grant;

    logic           slot_free;
    logic           any_vld;
    logic [IDW-1:0] gidx;
    logic           xfer;

    // Stage p0: grant selection and encoder drive (combinational)
    always_comb begin
        slot_free         = ~vld_p1 | bus.out_ready;
        {any_vld, gidx}   = rr_pick(bus.req_valid, last_grant);
        xfer              = slot_free & any_vld;
        bus.req_ready     = xfer ? (NREQ'(1) << gidx) : '0;
        enc_en            = xfer;
        enc_data_in       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer && gidx == IDW'(i))
                enc_data_in = CW'(bus.req_data[i*DW +: DW]);
        end
    end

    // Stage p1: output slot; a transfer refills it even when it is popped the same cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            vld_p1     <= 1'b0;
            code_p1    <= '0;
            id_p1      <= '0;
            cnt_p1     <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else if (xfer) begin
            vld_p1     <= 1'b1;
            code_p1    <= enc_data_out;
            id_p1      <= gidx;
            cnt_p1     <= cnt_p1 + 32'd1;
            last_grant <= gidx;
        end else if (bus.out_ready) begin
            vld_p1     <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_code  = code_p1;
    assign bus.out_id    = id_p1;
    assign enc_count     = cnt_p1;
    assign busy          = vld_p1 | (|bus.req_valid);

endmodule

// File: tb/tb_tbec_encode_arbiter.sv
// Directed and randomized bench for tbec_encode_arbiter against a cycle-level
// reference model of the grant rule and the one-word output slot.
module tb_tbec_encode_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int CW   = 32;
    localparam int IDW  = $clog2(NREQ);

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [CW-1:0]  enc_data_in;
    logic           enc_en;
    logic [CW-1:0]  enc_data_out;
    logic           busy;
    logic [31:0]    enc_count;

    tbec_encode_arbiter_if #(.NREQ(NREQ), .DW(DW), .CW(CW), .IDW(IDW)) bus ();

    tbec_encode_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .IDW(IDW)) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .bus          (bus.slave),
        .enc_data_in  (enc_data_in),
        .enc_en       (enc_en),
        .enc_data_out (enc_data_out),
        .busy         (busy),
        .enc_count    (enc_count)
    );

    assign enc_data_out = {enc_data_in[15:0], ~enc_data_in[15:0]};

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_last;
    logic        m_vld;
    logic [31:0] m_code;
    int          m_id;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = NREQ - 1;
        m_vld  = 1'b0;
        m_code = '0;
        m_id   = 0;
        m_cnt  = '0;
    endtask

    // One clock: drive inputs, check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic step(input logic rst, input logic [NREQ-1:0] v,
                        input logic [NREQ*DW-1:0] d, input logic ordy);
        bit          found;
        int          g;
        bit          xfer;
        logic [15:0] w;
        PRESET        = rst;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.out_ready = ordy;
        found = 0;
        g     = 0;
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = (m_last + off) % NREQ;
            if (!found && ((v >> idx) & NREQ'(1)) != '0) begin
                found = 1;
                g     = idx;
            end
        end
        xfer = found && (!m_vld || ordy);
        w    = d[g*DW +: DW];
        @(negedge PCLK);
        chk("req_ready", 64'(bus.req_ready), xfer ? 64'(NREQ'(1) << g) : 64'd0);
        chk("enc_en", 64'(enc_en), 64'(xfer));
        chk("enc_data_in", 64'(enc_data_in), xfer ? 64'(w) : 64'd0);
        chk("busy", 64'(busy), 64'(m_vld || (v != '0)));
        @(posedge PCLK);
        #1;
        if (rst) begin
            model_reset();
        end else if (xfer) begin
            m_vld  = 1'b1;
            m_code = {w, ~w};
            m_id   = g;
            m_cnt  = m_cnt + 32'd1;
            m_last = g;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
        chk("out_code", 64'(bus.out_code), 64'(m_code));
        chk("out_id", 64'(bus.out_id), 64'(m_id));
        chk("enc_count", 64'(enc_count), 64'(m_cnt));
    endtask

    function automatic logic [NREQ*DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [NREQ*DW-1:0] d;
        logic [CW-1:0]      held_code;
        PRESET        = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        model_reset();

        // Reset then idle
        step(1'b1, 4'b0000, '0, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_code", 64'(bus.out_code), 64'd0);
        chk("rst_enc_count", 64'(enc_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        step(1'b0, 4'b0000, '0, 1'b1);

        // Single requester 2
        d = '0;
        d[2*DW +: DW] = 16'hA5A5;
        step(1'b0, 4'b0100, d, 1'b1);
        chk("single_code", 64'(bus.out_code), 64'h0000_0000_A5A5_5A5A);
        chk("single_id", 64'(bus.out_id), 64'd2);
        chk("single_cnt", 64'(enc_count), 64'd1);
        step(1'b0, 4'b0000, '0, 1'b1);

        // Round robin after reset: grants 0,1,2,3,0,1
        step(1'b1, 4'b0000, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'b1111, rnd_data(), 1'b1);
            chk("rr_id", 64'(bus.out_id), 64'(k % NREQ));
            chk("rr_valid", 64'(bus.out_valid), 64'd1);
        end
        chk("rr_cnt", 64'(enc_count), 64'd6);

        // Backpressure with requester 1 waiting
        held_code = bus.out_code;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0010, rnd_data(), 1'b0);
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_code_held", 64'(bus.out_code), 64'(held_code));
        end
        d = rnd_data();
        step(1'b0, 4'b0010, d, 1'b1);
        chk("bp_release_id", 64'(bus.out_id), 64'd1);
        chk("bp_release_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_release_code", 64'(bus.out_code), 64'({d[DW +: DW], ~d[DW +: DW]}));

        // Reset while a word is pending and requester 0 is granted
        step(1'b1, 4'b0001, rnd_data(), 1'b1);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_cnt", 64'(enc_count), 64'd0);
        step(1'b0, 4'b1111, rnd_data(), 1'b1);
        chk("midrst_first_id", 64'(bus.out_id), 64'd0);

        // Counter wrap
        force dut.cnt_p1 = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_p1;
        m_cnt = 32'hFFFF_FFFF;
        chk("wrap_preload", 64'(enc_count), 64'h0000_0000_FFFF_FFFF);
        step(1'b0, 4'b0100, rnd_data(), 1'b1);
        chk("wrap_cnt", 64'(enc_count), 64'd0);

        // Randomized traffic with occasional backpressure and reset
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 63) == 0), NREQ'($urandom), rnd_data(),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
